// File: rtl/apb_master_arbiter.sv
// rtl/apb_master_arbiter.sv - round-robin APB master shared by several requesters
module apb_master_arbiter #(
  parameter int NO_OF_REQUESTERS  = 2,
  parameter int NO_OF_SLAVES      = 4,
  parameter int ADDRESS_WIDTH     = 32,
  parameter int DATA_WIDTH        = 32,
  parameter int SLAVE_MEMORY_SIZE = 12,
  parameter int SLAVE_MEMORY_GAP  = 2,
  parameter int MAX_WAIT          = 16
) (
  input  logic                                        pclk,
  input  logic                                        preset_n,
  input  logic [NO_OF_REQUESTERS-1:0]                 req_valid,
  output logic [NO_OF_REQUESTERS-1:0]                 req_ready,
  input  logic [NO_OF_REQUESTERS-1:0]                 req_write,
  input  logic [NO_OF_REQUESTERS*ADDRESS_WIDTH-1:0]   req_addr,
  input  logic [NO_OF_REQUESTERS*DATA_WIDTH-1:0]      req_wdata,
  input  logic [NO_OF_REQUESTERS*(DATA_WIDTH/8)-1:0]  req_strb,
  input  logic [NO_OF_REQUESTERS*3-1:0]               req_prot,
  output logic [NO_OF_REQUESTERS-1:0]                 rsp_valid,
  output logic [DATA_WIDTH-1:0]                       rsp_rdata,
  output logic                                        rsp_err,
  output logic [7:0]                                  rsp_wait_states,
  output logic [ADDRESS_WIDTH-1:0]                    paddr,
  output logic [NO_OF_SLAVES-1:0]                     pselx,
  output logic                                        penable,
  output logic                                        pwrite,
  output logic [DATA_WIDTH-1:0]                       pwdata,
  output logic [DATA_WIDTH/8-1:0]                     pstrb,
  output logic [2:0]                                  pprot,
  input  logic [DATA_WIDTH-1:0]                       prdata,
  input  logic                                        pready,
  input  logic                                        pslverr
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int GW         = (NO_OF_REQUESTERS > 1) ? $clog2(NO_OF_REQUESTERS) : 1;
  localparam int WCW        = 16;
  localparam logic [63:0] STRIDE = 64'(SLAVE_MEMORY_SIZE + SLAVE_MEMORY_GAP) * 64'd1024;
  localparam logic [63:0] WINDOW = 64'(SLAVE_MEMORY_SIZE) * 64'd1024;
  localparam logic [NO_OF_REQUESTERS-1:0] REQ_ONE  = NO_OF_REQUESTERS'(1);
  localparam logic [GW-1:0]               LAST_RST = GW'(NO_OF_REQUESTERS - 1);
  localparam logic [WCW-1:0]              WAIT_MAX = WCW'(MAX_WAIT);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_ERR} state_t;

  state_t                  state, state_next;
  logic [GW-1:0]           last_grant, gnt_q, win;
  logic                    found, grant, dec_hit, timeout;
  logic [WCW-1:0]          wait_cnt;
  logic [7:0]              wait_sat;
  logic [NO_OF_SLAVES-1:0] sel_q, dec_sel;
  logic [ADDRESS_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0]   win_wdata;
  logic [STRB_WIDTH-1:0]   win_strb;
  logic [2:0]              win_prot;
  logic                    win_write;
  logic [63:0]             addr_ext;

  // Round-robin pick starting one past the last grant, then mux the winner's fields
  always_comb begin
    found     = 1'b0;
    win       = '0;
    win_addr  = '0;
    win_wdata = '0;
    win_strb  = '0;
    win_prot  = '0;
    win_write = 1'b0;
    for (int k = 1; k <= NO_OF_REQUESTERS; k++) begin
      for (int i = 0; i < NO_OF_REQUESTERS; i++) begin
        if (!found && req_valid[i] && ((int'(last_grant) + k) % NO_OF_REQUESTERS) == i) begin
          found = 1'b1;
          win   = GW'(i);
        end
      end
    end
    for (int i = 0; i < NO_OF_REQUESTERS; i++) begin
      if (win == GW'(i)) begin
        win_addr  = req_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        win_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        win_strb  = req_strb[i*STRB_WIDTH +: STRB_WIDTH];
        win_prot  = req_prot[i*3 +: 3];
        win_write = req_write[i];
      end
    end
  end

  // Fixed memory map decode of the winning address; gaps and out-of-range miss
  always_comb begin
    addr_ext = 64'(win_addr);
    dec_sel  = '0;
    for (int i = 0; i < NO_OF_SLAVES; i++) begin
      if ((addr_ext >= 64'(i) * STRIDE) && (addr_ext < 64'(i) * STRIDE + WINDOW)) begin
        dec_sel[i] = 1'b1;
      end
    end
  end

  assign dec_hit  = |dec_sel;
  assign grant    = preset_n && (state == S_IDLE) && found;
  assign timeout  = (wait_cnt == WAIT_MAX);
  assign wait_sat = (wait_cnt > WCW'(255)) ? 8'hFF : wait_cnt[7:0];

  // State register
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) state <= S_IDLE;
    else           state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (grant) state_next = dec_hit ? S_SETUP : S_ERR;
      S_SETUP:  state_next = S_ACCESS;
      S_ACCESS: if (pready || timeout) state_next = S_IDLE;
      S_ERR:    state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Combinational outputs: grant strobe and APB select/enable phases
  always_comb begin
    req_ready = '0;
    pselx     = '0;
    penable   = 1'b0;
    if (grant) req_ready = REQ_ONE << win;
    if (state == S_SETUP) pselx = sel_q;
    if (state == S_ACCESS) begin
      pselx   = sel_q;
      penable = 1'b1;
    end
  end

  // Request capture at grant, wait counting and registered responses
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      last_grant      <= LAST_RST;
      gnt_q           <= '0;
      sel_q           <= '0;
      wait_cnt        <= '0;
      paddr           <= '0;
      pwrite          <= 1'b0;
      pwdata          <= '0;
      pstrb           <= '0;
      pprot           <= '0;
      rsp_valid       <= '0;
      rsp_rdata       <= '0;
      rsp_err         <= 1'b0;
      rsp_wait_states <= '0;
    end else begin
      rsp_valid <= '0;
      if (grant) begin
        last_grant <= win;
        gnt_q      <= win;
        sel_q      <= dec_sel;
        wait_cnt   <= '0;
        paddr      <= win_addr;
        pwrite     <= win_write;
        pwdata     <= win_wdata;
        pstrb      <= win_write ? win_strb : '0;
        pprot      <= win_prot;
      end
      case (state)
        S_ACCESS: begin
          if (pready) begin
            rsp_valid       <= REQ_ONE << gnt_q;
            rsp_err         <= pslverr;
            rsp_rdata       <= pwrite ? '0 : prdata;
            rsp_wait_states <= wait_sat;
          end else if (timeout) begin
            rsp_valid       <= REQ_ONE << gnt_q;
            rsp_err         <= 1'b1;
            rsp_rdata       <= '0;
            rsp_wait_states <= wait_sat;
          end else begin
            wait_cnt <= wait_cnt + WCW'(1);
          end
        end
        S_ERR: begin
          rsp_valid       <= REQ_ONE << gnt_q;
          rsp_err         <= 1'b1;
          rsp_rdata       <= '0;
          rsp_wait_states <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb/tb_apb_master_arbiter.sv - directed self-checking bench for apb_master_arbiter
module tb_apb_master_arbiter;

  logic        pclk = 1'b0;
  logic        preset_n;
  logic [1:0]  req_valid, req_ready, req_write, rsp_valid;
  logic [63:0] req_addr, req_wdata;
  logic [7:0]  req_strb;
  logic [5:0]  req_prot;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [7:0]  rsp_wait_states;
  logic [31:0] paddr, pwdata, prdata;
  logic [3:0]  pselx, pstrb;
  logic        penable, pwrite, pready, pslverr;
  logic [2:0]  pprot;

  int n_pass, n_total;
  logic [1:0] exp_ready;

  apb_master_arbiter dut (
    .pclk(pclk), .preset_n(preset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_wait_states(rsp_wait_states),
    .paddr(paddr), .pselx(pselx), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic smp();
    @(negedge pclk);
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    preset_n = 1'b0; req_valid = 2'b11; req_write = '0; req_addr = '0; req_wdata = '0;
    req_strb = '0; req_prot = '0; prdata = '0; pready = 1'b0; pslverr = 1'b0;

    // reset state
    #12;
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_pselx", pselx, 4'b0000);
    chk("rst_penable", penable, 1'b0);
    chk("rst_paddr", paddr, 32'h0);
    chk("rst_pwdata", pwdata, 32'h0);
    chk("rst_pwrite", pwrite, 1'b0);
    chk("rst_pstrb", pstrb, 4'h0);
    chk("rst_pprot", pprot, 3'h0);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_rsp_wait", rsp_wait_states, 8'h0);
    req_valid = 2'b00;
    tick(); preset_n = 1'b1;

    // single read, requester 0, zero wait states
    tick(); req_valid = 2'b01; req_addr[31:0] = 32'h10; req_prot[2:0] = 3'b010; req_strb[3:0] = 4'hA;
    smp(); chk("rd_ready", req_ready, 2'b01);
    tick(); req_valid = 2'b00; req_addr[31:0] = 32'hFFFF_0000;
    smp();
    chk("rd_setup_psel", pselx, 4'b0001);
    chk("rd_setup_penable", penable, 1'b0);
    chk("rd_paddr", paddr, 32'h10);
    chk("rd_pwrite", pwrite, 1'b0);
    chk("rd_pstrb", pstrb, 4'h0);
    chk("rd_pprot", pprot, 3'b010);
    chk("rd_setup_ready", req_ready, 2'b00);
    tick(); pready = 1'b1; prdata = 32'hDEAD_BEEF;
    smp(); chk("rd_access_psel", pselx, 4'b0001); chk("rd_access_penable", penable, 1'b1);
    tick(); pready = 1'b0; prdata = 32'h0;
    smp();
    chk("rd_rsp_valid", rsp_valid, 2'b01);
    chk("rd_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
    chk("rd_rsp_err", rsp_err, 1'b0);
    chk("rd_rsp_wait", rsp_wait_states, 8'd0);
    chk("rd_idle_psel", pselx, 4'b0000);
    chk("rd_idle_paddr_hold", paddr, 32'h10);

    // write, requester 1, slave 1 base, 3 wait states
    tick(); req_valid = 2'b10; req_write = 2'b10; req_addr[63:32] = 32'h3800;
    req_wdata[63:32] = 32'h1234_5678; req_strb[7:4] = 4'hF; req_prot[5:3] = 3'b001;
    smp(); chk("wr_ready", req_ready, 2'b10); chk("wr_rsp_pulse_gone", rsp_valid, 2'b00);
    tick(); req_valid = 2'b00;
    smp();
    chk("wr_psel", pselx, 4'b0010);
    chk("wr_pwrite", pwrite, 1'b1);
    chk("wr_pwdata", pwdata, 32'h1234_5678);
    chk("wr_pstrb", pstrb, 4'hF);
    chk("wr_pprot", pprot, 3'b001);
    for (int c = 0; c < 4; c++) begin
      tick(); pready = (c == 3); prdata = 32'hFFFF_FFFF;
      smp(); chk("wr_penable", penable, 1'b1); chk("wr_access_psel", pselx, 4'b0010);
    end
    tick(); pready = 1'b0;
    smp();
    chk("wr_rsp_valid", rsp_valid, 2'b10);
    chk("wr_rsp_wait", rsp_wait_states, 8'd3);
    chk("wr_rsp_rdata", rsp_rdata, 32'h0);
    chk("wr_rsp_err", rsp_err, 1'b0);

    // round robin: both requesters hold valid for four transfers
    tick(); req_valid = 2'b11; req_write = 2'b00; req_addr = {32'h7000, 32'h100};
    pready = 1'b1; prdata = 32'h0000_5A5A;
    for (int t = 0; t <= 12; t++) begin
      if (t > 0) begin
        tick();
        if (t == 10) req_valid = 2'b00;
      end
      smp();
      if ((t % 3 == 0) && (t <= 9)) exp_ready = ((t / 3) % 2 == 0) ? 2'b01 : 2'b10;
      else exp_ready = 2'b00;
      chk("rr_ready", req_ready, exp_ready);
      if (t % 3 == 1) chk("rr_psel", pselx, ((t / 3) % 2 == 0) ? 4'b0001 : 4'b0100);
      if ((t % 3 == 0) && (t > 0)) begin
        chk("rr_rsp_valid", rsp_valid, ((t / 3) % 2 == 1) ? 2'b01 : 2'b10);
        chk("rr_rsp_rdata", rsp_rdata, 32'h0000_5A5A);
      end
    end

    // decode miss in the gap after slave 0
    tick(); pready = 1'b0; req_valid = 2'b01; req_addr[31:0] = 32'h3000;
    smp(); chk("miss_ready", req_ready, 2'b01);
    tick(); req_valid = 2'b00;
    smp(); chk("miss_psel", pselx, 4'b0000); chk("miss_penable", penable, 1'b0);
    chk("miss_no_rsp_yet", rsp_valid, 2'b00);
    tick();
    smp();
    chk("miss_rsp_valid", rsp_valid, 2'b01);
    chk("miss_rsp_err", rsp_err, 1'b1);
    chk("miss_rsp_rdata", rsp_rdata, 32'h0);
    chk("miss_rsp_wait", rsp_wait_states, 8'd0);

    // pready timeout on slave 2, requester 1
    tick(); req_valid = 2'b10; req_addr[63:32] = 32'h7004;
    smp(); chk("to_ready", req_ready, 2'b10);
    tick(); req_valid = 2'b00;
    smp(); chk("to_setup_psel", pselx, 4'b0100);
    for (int c = 0; c <= 16; c++) begin
      tick();
      smp(); chk("to_penable", penable, 1'b1); chk("to_no_rsp", rsp_valid, 2'b00);
    end
    tick();
    smp();
    chk("to_rsp_valid", rsp_valid, 2'b10);
    chk("to_rsp_err", rsp_err, 1'b1);
    chk("to_rsp_rdata", rsp_rdata, 32'h0);
    chk("to_psel", pselx, 4'b0000);
    chk("to_penable_off", penable, 1'b0);

    // next request after the timeout completes normally
    tick(); req_valid = 2'b01; req_addr[31:0] = 32'h20;
    smp(); chk("post_to_ready", req_ready, 2'b01);
    tick(); req_valid = 2'b00;
    smp();
    tick(); pready = 1'b1; prdata = 32'hCAFE_F00D;
    smp();
    tick(); pready = 1'b0;
    smp();
    chk("post_to_rsp_valid", rsp_valid, 2'b01);
    chk("post_to_rdata", rsp_rdata, 32'hCAFE_F00D);
    chk("post_to_err", rsp_err, 1'b0);

    // asynchronous reset during ACCESS
    tick(); req_valid = 2'b10; req_write = 2'b10; req_addr[63:32] = 32'h40; req_wdata[63:32] = 32'hA5A5_A5A5;
    smp(); chk("ar_ready", req_ready, 2'b10);
    tick(); req_valid = 2'b00;
    smp();
    tick();
    smp(); chk("ar_access_penable", penable, 1'b1); chk("ar_access_psel", pselx, 4'b0001);
    #1; preset_n = 1'b0; req_valid = 2'b11;
    #1;
    chk("ar_psel", pselx, 4'b0000);
    chk("ar_penable", penable, 1'b0);
    chk("ar_paddr", paddr, 32'h0);
    chk("ar_pwdata", pwdata, 32'h0);
    chk("ar_pwrite", pwrite, 1'b0);
    chk("ar_rsp_valid", rsp_valid, 2'b00);
    chk("ar_req_ready", req_ready, 2'b00);
    tick();
    smp(); chk("ar_hold_rsp_valid", rsp_valid, 2'b00);
    tick(); preset_n = 1'b1;
    smp(); chk("ar_first_grant", req_ready, 2'b01);
    tick(); req_valid = 2'b00;
    smp(); chk("ar_after_psel", pselx, 4'b0001); chk("ar_after_rsp", rsp_valid, 2'b00);
    tick(); pready = 1'b1; prdata = 32'h0BAD_F00D;
    smp();
    tick(); pready = 1'b0;
    smp();
    chk("ar_after_rsp_valid", rsp_valid, 2'b01);
    chk("ar_after_rdata", rsp_rdata, 32'h0BAD_F00D);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/apb_master_arbiter.md
# apb_master_arbiter

Shares a single APB master port between NO_OF_REQUESTERS internal requesters and sequences the APB IDLE/SETUP/ACCESS protocol on their behalf. Grants requesters round-robin, decodes the address into a one-hot pselx using the fixed slave memory map, counts wait states, and enforces a pready timeout. Sits between the requester-side sequencing logic and the APB slave bus. The response mux that feeds prdata/pready/pslverr is external.

## Interface
Parameters:
- NO_OF_REQUESTERS, 2: number of requesters (1..8).
- NO_OF_SLAVES, 4: width of pselx (1..16).
- ADDRESS_WIDTH, 32: paddr width.
- DATA_WIDTH, 32: pwdata/prdata width; pstrb is DATA_WIDTH/8.
- SLAVE_MEMORY_SIZE, 12: per-slave window, KB.
- SLAVE_MEMORY_GAP, 2: unmapped gap after each window, KB.
- MAX_WAIT, 16: pready-low cycles tolerated in ACCESS before abort.

Ports, with R = NO_OF_REQUESTERS:
- pclk  in  1  clock; one clock domain, everything on the rising edge.
- preset_n  in  1  asynchronous, active-low reset.
- req_valid  in  R  per-requester request.
- req_ready  out  R  grant/accept, one-hot, combinational.
- req_write  in  R  1 = WRITE, 0 = READ.
- req_addr  in  R*ADDRESS_WIDTH  requester i occupies slice i.
- req_wdata  in  R*DATA_WIDTH  write data.
- req_strb  in  R*DATA_WIDTH/8  byte strobes.
- req_prot  in  R*3  protection type.
- rsp_valid  out  R  one-hot completion pulse, 1 cycle.
- rsp_rdata  out  DATA_WIDTH  read data; valid with rsp_valid.
- rsp_err  out  1  1 = slave error, decode miss or timeout.
- rsp_wait_states  out  8  wait states observed, saturating at 255.
- paddr  out  ADDRESS_WIDTH  APB address.
- pselx  out  NO_OF_SLAVES  one-hot slave select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- pwdata  out  DATA_WIDTH  APB write data.
- pstrb  out  DATA_WIDTH/8  APB strobes.
- pprot  out  3  APB protection.
- prdata  in  DATA_WIDTH  selected slave read data.
- pready  in  1  selected slave ready.
- pslverr  in  1  selected slave error.

## Operation
- FSM states: IDLE, SETUP, ACCESS, ERR.
- IDLE:
  - If any req_valid is high, the arbiter picks winner g and drives req_ready[g]=1 that cycle (valid&ready handshake).
  - On the edge, the block latches g's fields and decodes the address.
  - Decode hit: go to SETUP. Decode miss: go to ERR.
- Round-robin arbitration: search starts at last_grant+1, modulo R. last_grant resets to R-1, so requester 0 wins first. last_grant updates on every grant.
- Address decode:
  - stride = (SLAVE_MEMORY_SIZE+SLAVE_MEMORY_GAP)*1024.
  - Slave i is hit when i*stride <= addr < i*stride + SLAVE_MEMORY_SIZE*1024, for i < NO_OF_SLAVES.
  - pselx[i]=1 on a hit.
  - Any other address, including gaps and addresses beyond the last slave, is a miss.
- SETUP: pselx valid, penable=0. Unconditional move to ACCESS.
- ACCESS:
  - penable=1 while pready=0; the wait counter increments each cycle.
  - When pready=1: latch prdata and pslverr, return to IDLE, and pulse rsp_valid[g] with rsp_err=pslverr.
  - When the wait count reaches MAX_WAIT with pready still 0: abort, deassert pselx/penable, return to IDLE, rsp_err=1, rsp_rdata=0.
- ERR: one cycle with no APB activity. Next cycle rsp_valid[g]=1, rsp_err=1, rsp_rdata=0, rsp_wait_states=0. Then IDLE.
- Reads: pstrb driven 0, and rsp_rdata carries the latched prdata. Writes: rsp_rdata=0.
- Between transfers (IDLE/ERR): pselx=0, penable=0. paddr, pwrite, pwdata and pprot hold their last values.

## Timing
- Reset values: pselx=0, penable=0, paddr=0, pwrite=0, pwdata=0, pstrb=0, pprot=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, rsp_wait_states=0, state=IDLE. req_ready=0 while preset_n=0.
- Asserting preset_n mid-transfer drops the transfer immediately (asynchronously) with no rsp_valid.
- Minimum transfer (no wait states): grant at cycle 0, SETUP at 1, ACCESS at 2, rsp_valid at 3.
- IDLE may grant in the same cycle that rsp_valid is high, giving a 3-cycle back-to-back period.
- rsp_* outputs are registered. Requester fields are sampled only at the grant edge and may change after req_ready.
- An ACCESS with k wait states lasts k+1 cycles and reports rsp_wait_states=k.
- Timeout: rsp_valid occurs MAX_WAIT+1 cycles after ACCESS entry.
- req_ready is never asserted outside IDLE. At most one requester is granted per cycle.

## Test plan
- Single read, requester 0, addr 0x0000_0010, pready=1 immediately, prdata=0xDEAD_BEEF -> pselx=4'b0001 for 2 cycles; rsp_valid[0] at cycle 3 with rdata 0xDEAD_BEEF, err=0, wait=0.
- Write to addr 0x0000_3800 (slave 1 base = 14 KB), strb 4'hF, 3 wait states -> pselx=4'b0010, pstrb=4'hF, penable high 4 cycles; rsp_wait_states=3, rsp_rdata=0.
- Decode miss at addr 0x0000_3000 (gap) -> pselx stays 0; rsp_valid with err=1 two cycles after grant.
- Both requesters hold valid for 4 transfers -> grants alternate 0,1,0,1 with 3-cycle spacing.
- pready held low with MAX_WAIT=16 -> abort after 16 ACCESS wait cycles, rsp_err=1, pselx=0; the next request proceeds normally.
- preset_n pulsed low during ACCESS -> all outputs 0 at once, no rsp_valid; requester 0 is granted first after release.
